// File: rtl/sym_err_counter_pkg.sv
// Shared types and defaults for the symbol-error measurement stage.
package sym_err_counter_pkg;

    localparam int LFSR_LEN    = 22;
    localparam int SYM_WID_DEF = 2;
    localparam int CNT_WID_DEF = LFSR_LEN;
    localparam int DELAY_DEF   = 3;

    typedef enum logic {
        WAIT_SYNC = 1'b0,
        MEASURE   = 1'b1
    } state_t;

endpackage

// File: rtl/sym_err_counter_sat_counter.sv
// Running counter that holds at all-ones instead of wrapping and remembers
// that it did so until cleared.
module sat_counter
    import sym_err_counter_pkg::*;
#(
    parameter int WID = CNT_WID_DEF
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_clear,
    input  logic           i_inc_en,
    input  logic           i_inc,
    output logic [WID-1:0] o_count,
    output logic           o_sat
);

    logic [WID-1:0] r_count;
    logic           r_sat;
    logic           w_full;

    assign w_full = &r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (i_clear) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (i_inc_en && i_inc) begin
            if (w_full) begin
                r_sat <= 1'b1;
            end else begin
                r_count <= r_count + WID'(1);
            end
        end
    end

    assign o_count = r_count;
    assign o_sat   = r_sat;

endmodule

// File: rtl/sym_err_counter.sv
// Compares delayed LFSR reference symbols with I/Q slicer decisions and
// latches per-LFSR-period error and symbol counts for readout.
module sym_err_counter
    import sym_err_counter_pkg::*;
#(
    parameter int DELAY   = DELAY_DEF,
    parameter int CNT_WID = CNT_WID_DEF,
    parameter int SYM_WID = SYM_WID_DEF
) (
    input  logic               sys_clk,
    input  logic               reset,
    input  logic               sym_clk_en,
    input  logic               clr_acc,
    input  logic [SYM_WID-1:0] ref_sym_i,
    input  logic [SYM_WID-1:0] ref_sym_q,
    input  logic [SYM_WID-1:0] slice_i,
    input  logic [SYM_WID-1:0] slice_q,
    output logic [CNT_WID-1:0] err_cnt_i,
    output logic [CNT_WID-1:0] err_cnt_q,
    output logic [CNT_WID-1:0] sym_cnt,
    output logic               win_done,
    output logic               meas_valid,
    output logic               saturated
);

    logic [SYM_WID-1:0] r_dly_i [DELAY];
    logic [SYM_WID-1:0] r_dly_q [DELAY];

    state_t r_state;
    state_t w_state_next;

    logic w_boundary, w_err_i, w_err_q;
    logic w_clear, w_count_en, w_latch;

    logic [CNT_WID-1:0] w_cnt_i, w_cnt_q, w_cnt_s;
    logic               w_sat_i, w_sat_q, w_sat_s;
    logic [CNT_WID:0]   w_close_i, w_close_q, w_close_s;

    logic [CNT_WID-1:0] r_err_cnt_i, r_err_cnt_q, r_sym_cnt;
    logic               r_win_done, r_meas_valid, r_saturated;

    // Reference delay lines track the mapper-to-slicer latency in every state.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DELAY; k++) begin
                r_dly_i[k] <= '0;
                r_dly_q[k] <= '0;
            end
        end else if (sym_clk_en) begin
            r_dly_i[0] <= ref_sym_i;
            r_dly_q[0] <= ref_sym_q;
            for (int k = 1; k < DELAY; k++) begin
                r_dly_i[k] <= r_dly_i[k-1];
                r_dly_q[k] <= r_dly_q[k-1];
            end
        end
    end

    assign w_boundary = clr_acc && sym_clk_en;
    assign w_err_i    = sym_clk_en && (r_dly_i[DELAY-1] != slice_i);
    assign w_err_q    = sym_clk_en && (r_dly_q[DELAY-1] != slice_q);

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_state <= WAIT_SYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_count_en   = 1'b0;
        w_latch      = 1'b0;
        case (r_state)
            WAIT_SYNC: begin
                if (w_boundary) begin
                    w_state_next = MEASURE;
                    w_clear      = 1'b1;
                end
            end
            MEASURE: begin
                if (w_boundary) begin
                    w_latch = 1'b1;
                    w_clear = 1'b1;
                end else if (sym_clk_en) begin
                    w_count_en = 1'b1;
                end
            end
            default: w_state_next = WAIT_SYNC;
        endcase
    end

    sat_counter #(.WID(CNT_WID)) u_cnt_err_i (
        .i_clk    (sys_clk),
        .i_rst    (reset),
        .i_clear  (w_clear),
        .i_inc_en (w_count_en),
        .i_inc    (w_err_i),
        .o_count  (w_cnt_i),
        .o_sat    (w_sat_i)
    );

    sat_counter #(.WID(CNT_WID)) u_cnt_err_q (
        .i_clk    (sys_clk),
        .i_rst    (reset),
        .i_clear  (w_clear),
        .i_inc_en (w_count_en),
        .i_inc    (w_err_q),
        .o_count  (w_cnt_q),
        .o_sat    (w_sat_q)
    );

    sat_counter #(.WID(CNT_WID)) u_cnt_sym (
        .i_clk    (sys_clk),
        .i_rst    (reset),
        .i_clear  (w_clear),
        .i_inc_en (w_count_en),
        .i_inc    (1'b1),
        .o_count  (w_cnt_s),
        .o_sat    (w_sat_s)
    );

    // The boundary symbol closes the window: add it with the same clamp,
    // returning {overflow, value}.
    function automatic logic [CNT_WID:0] close_val(input logic [CNT_WID-1:0] c,
                                                   input logic inc);
        logic ovf;
        ovf = inc && (&c);
        return {ovf, (ovf ? c : c + CNT_WID'(inc))};
    endfunction

    assign w_close_i = close_val(w_cnt_i, w_err_i);
    assign w_close_q = close_val(w_cnt_q, w_err_q);
    assign w_close_s = close_val(w_cnt_s, 1'b1);

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_err_cnt_i  <= '0;
            r_err_cnt_q  <= '0;
            r_sym_cnt    <= '0;
            r_win_done   <= 1'b0;
            r_meas_valid <= 1'b0;
            r_saturated  <= 1'b0;
        end else begin
            r_win_done <= w_latch;
            if (w_latch) begin
                r_err_cnt_i  <= w_close_i[CNT_WID-1:0];
                r_err_cnt_q  <= w_close_q[CNT_WID-1:0];
                r_sym_cnt    <= w_close_s[CNT_WID-1:0];
                r_saturated  <= w_sat_i || w_sat_q || w_sat_s ||
                                w_close_i[CNT_WID] || w_close_q[CNT_WID] ||
                                w_close_s[CNT_WID];
                r_meas_valid <= 1'b1;
            end
        end
    end

    assign err_cnt_i  = r_err_cnt_i;
    assign err_cnt_q  = r_err_cnt_q;
    assign sym_cnt    = r_sym_cnt;
    assign win_done   = r_win_done;
    assign meas_valid = r_meas_valid;
    assign saturated  = r_saturated;

endmodule

// File: tb/tb_sym_err_counter.sv
// Scoreboard bench: two instances (22-bit and 4-bit counters) share stimulus;
// expected window results are queued at issue and checked on win_done.
module tb_sym_err_counter;

    logic       sys_clk = 1'b0;
    logic       reset;
    logic       sym_clk_en;
    logic       clr_acc;
    logic [1:0] ref_sym_i, ref_sym_q, slice_i, slice_q;

    logic [21:0] err_cnt_i, err_cnt_q, sym_cnt;
    logic        win_done, meas_valid, saturated;
    logic [3:0]  n_err_cnt_i, n_err_cnt_q, n_sym_cnt;
    logic        n_win_done, n_meas_valid, n_saturated;

    always #5 sys_clk = ~sys_clk;

    sym_err_counter dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .sym_clk_en (sym_clk_en),
        .clr_acc    (clr_acc),
        .ref_sym_i  (ref_sym_i),
        .ref_sym_q  (ref_sym_q),
        .slice_i    (slice_i),
        .slice_q    (slice_q),
        .err_cnt_i  (err_cnt_i),
        .err_cnt_q  (err_cnt_q),
        .sym_cnt    (sym_cnt),
        .win_done   (win_done),
        .meas_valid (meas_valid),
        .saturated  (saturated)
    );

    sym_err_counter #(.CNT_WID(4)) dut_n (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .sym_clk_en (sym_clk_en),
        .clr_acc    (clr_acc),
        .ref_sym_i  (ref_sym_i),
        .ref_sym_q  (ref_sym_q),
        .slice_i    (slice_i),
        .slice_q    (slice_q),
        .err_cnt_i  (n_err_cnt_i),
        .err_cnt_q  (n_err_cnt_q),
        .sym_cnt    (n_sym_cnt),
        .win_done   (n_win_done),
        .meas_valid (n_meas_valid),
        .saturated  (n_saturated)
    );

    typedef struct {
        int   ei_lo;
        int   ei_hi;
        int   eq_lo;
        int   eq_hi;
        int   sc;
        logic sat;
    } exp_t;

    exp_t exp_w[$];
    exp_t exp_n[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   w_pulses = 0;
    int   n_pulses = 0;
    logic prev_w = 1'b0;
    logic prev_n = 1'b0;
    logic [1:0] h_i [3];
    logic [1:0] h_q [3];

    task automatic check(input string name, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic check_win(input string tag, input exp_t e, input int ei, input int eq,
                             input int sc, input logic sat, input logic mv);
        check({tag, ".err_cnt_i"}, ei, e.ei_lo, e.ei_hi);
        check({tag, ".err_cnt_q"}, eq, e.eq_lo, e.eq_hi);
        check({tag, ".sym_cnt"}, sc, e.sc, e.sc);
        check({tag, ".saturated"}, int'(sat), int'(e.sat), int'(e.sat));
        check({tag, ".meas_valid"}, int'(mv), 1, 1);
        $display("window %s: err_i=%0d err_q=%0d sym=%0d sat=%0d", tag, ei, eq, sc, sat);
    endtask

    // Wide-instance monitor
    always @(negedge sys_clk) begin
        if (win_done) begin
            w_pulses++;
            check("wide.win_done_width", int'(prev_w), 0, 0);
            if (exp_w.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL wide.unexpected_win_done: got pulse, want none");
            end else begin
                check_win("wide", exp_w.pop_front(), int'(err_cnt_i), int'(err_cnt_q),
                          int'(sym_cnt), saturated, meas_valid);
            end
        end
        prev_w <= win_done;
    end

    // Narrow-instance monitor
    always @(negedge sys_clk) begin
        if (n_win_done) begin
            n_pulses++;
            check("narrow.win_done_width", int'(prev_n), 0, 0);
            if (exp_n.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL narrow.unexpected_win_done: got pulse, want none");
            end else begin
                check_win("narrow", exp_n.pop_front(), int'(n_err_cnt_i), int'(n_err_cnt_q),
                          int'(n_sym_cnt), n_saturated, n_meas_valid);
            end
        end
        prev_n <= n_win_done;
    end

    function automatic int cl4(input int x);
        return (x > 15) ? 15 : x;
    endfunction

    task automatic push_exp(input int ei_lo, input int ei_hi, input int eq_lo,
                            input int eq_hi, input int sc);
        exp_t e;
        e = '{ei_lo, ei_hi, eq_lo, eq_hi, sc, 1'b0};
        exp_w.push_back(e);
        e = '{cl4(ei_lo), cl4(ei_hi), cl4(eq_lo), cl4(eq_hi), cl4(sc),
              (sc > 15) || (ei_lo > 15) || (eq_lo > 15)};
        exp_n.push_back(e);
    endtask

    task automatic clear_hist();
        for (int k = 0; k < 3; k++) begin
            h_i[k] = 2'b00;
            h_q[k] = 2'b00;
        end
    endtask

    // One symbol: sym_clk_en high for one sys_clk, then an idle sys_clk.
    task automatic sym_step(input logic clr, input logic fi, input logic fq,
                            input logic mis, input logic keep);
        logic [1:0] ri, rq;
        @(posedge sys_clk);
        #1;
        ri = 2'($urandom_range(0, 3));
        rq = 2'($urandom_range(0, 3));
        ref_sym_i = ri;
        ref_sym_q = rq;
        slice_i = mis ? h_i[1] : (h_i[2] ^ {1'b0, fi});
        slice_q = mis ? h_q[1] : (h_q[2] ^ {1'b0, fq});
        sym_clk_en = 1'b1;
        clr_acc = clr;
        h_i[2] = h_i[1]; h_i[1] = h_i[0]; h_i[0] = ri;
        h_q[2] = h_q[1]; h_q[1] = h_q[0]; h_q[0] = rq;
        @(posedge sys_clk);
        #1;
        sym_clk_en = 1'b0;
        if (!keep) clr_acc = 1'b0;
    endtask

    // Window of n symbols numbered 1..n; the last one carries the boundary.
    task automatic window(input int n, input int fi_a, input int fi_b, input int fq_a,
                          input logic mis, input logic all_i);
        for (int k = 1; k <= n; k++) begin
            sym_step(k == n, (k == fi_a) || (k == fi_b) || all_i, k == fq_a, mis, 1'b0);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".err_cnt_i"}, int'(err_cnt_i), 0, 0);
        check({tag, ".err_cnt_q"}, int'(err_cnt_q), 0, 0);
        check({tag, ".sym_cnt"}, int'(sym_cnt), 0, 0);
        check({tag, ".win_done"}, int'(win_done), 0, 0);
        check({tag, ".meas_valid"}, int'(meas_valid), 0, 0);
        check({tag, ".saturated"}, int'(saturated), 0, 0);
        check({tag, ".narrow_meas_valid"}, int'(n_meas_valid), 0, 0);
    endtask

    initial begin
        int p0;
        reset = 1'b1;
        sym_clk_en = 1'b0;
        clr_acc = 1'b0;
        ref_sym_i = '0; ref_sym_q = '0;
        slice_i = '0; slice_q = '0;
        clear_hist();
        repeat (3) @(posedge sys_clk);
        #1 reset = 1'b0;
        check_zero("reset");

        // Sync, one full window, then reset 5 symbols into the next window
        sym_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp(0, 0, 0, 0, 10);
        window(10, 0, 0, 0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) sym_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge sys_clk);
        #3 reset = 1'b1;
        #1 check_zero("mid_reset");
        clear_hist();
        @(posedge sys_clk);
        #1 reset = 1'b0;
        p0 = w_pulses;
        sym_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge sys_clk);
        check("no_latch_after_reset", w_pulses - p0, 0, 0);

        // Perfect alignment
        push_exp(0, 0, 0, 0, 10);
        window(10, 0, 0, 0, 1'b0, 1'b0);

        // Error injection
        push_exp(2, 2, 1, 1, 10);
        window(10, 2, 7, 4, 1'b0, 1'b0);

        // Misalignment by one symbol: ~3/4 of symbols in error
        push_exp(700, 800, 700, 800, 1000);
        window(1000, 0, 0, 0, 1'b1, 1'b0);

        // Every I symbol wrong: narrow instance saturates
        push_exp(20, 20, 0, 0, 20);
        window(20, 0, 0, 0, 1'b0, 1'b1);
        push_exp(0, 0, 0, 0, 10);
        window(10, 0, 0, 0, 1'b0, 1'b0);

        // clr_acc held 4 sys_clk around one enable: exactly one boundary
        push_exp(0, 0, 0, 0, 5);
        for (int k = 0; k < 4; k++) sym_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge sys_clk);
        #1 clr_acc = 1'b1;
        p0 = w_pulses;
        sym_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(posedge sys_clk);
        #1 clr_acc = 1'b0;
        repeat (2) @(posedge sys_clk);
        check("held_clr_pulses", w_pulses - p0, 1, 1);

        // clr_acc with sym_clk_en low is ignored
        push_exp(0, 0, 0, 0, 6);
        for (int k = 0; k < 3; k++) sym_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        p0 = w_pulses;
        @(posedge sys_clk);
        #1 clr_acc = 1'b1;
        @(posedge sys_clk);
        #1 clr_acc = 1'b0;
        repeat (2) @(posedge sys_clk);
        check("clr_without_en_pulses", w_pulses - p0, 0, 0);
        window(3, 0, 0, 0, 1'b0, 1'b0);

        // Boundaries on consecutive symbols: 1-symbol windows
        push_exp(0, 0, 0, 0, 1);
        sym_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp(1, 1, 0, 0, 1);
        sym_step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        repeat (4) @(posedge sys_clk);
        check("wide.queue_empty", exp_w.size(), 0, 0);
        check("narrow.queue_empty", exp_n.size(), 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
